// File: rtl/deb_multi.sv
// Multi-channel debouncer: per-channel 2-FF synchroniser, saturating stability counter, level + edge pulses.
// Latency: CNT_MAX+2 clocks from input capture to out/rise/fall with tick held high; scales with tick rate.
// Backpressure: none; free-running, every channel evaluated every clock independently.
module deb_multi #(
    parameter int   CH      = 8,
    parameter int   CNT_W   = 8,
    parameter logic RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          any_change
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH-1:0] ff0;
    logic [CH-1:0] ff1;
    logic [CH-1:0] chg;
    logic [CH-1:0] stable;
    logic [CH-1:0] upd;
    logic [CH-1:0] rise_nxt;
    logic [CH-1:0] fall_nxt;

    // Two-stage synchroniser; both stages reset to the idle level so release causes no fake edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff0 <= {CH{RST_VAL}};
            ff1 <= {CH{RST_VAL}};
        end else begin
            ff0 <= in;
            ff1 <= ff0;
        end
    end

    // A difference between the stages means the synchronised level is about to move
    assign chg = ff0 ^ ff1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        // Stability counter: any change restarts it regardless of tick; saturates at CNT_MAX
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (chg[i]) begin
                cnt <= '0;
            end else if (tick && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end

        // Stability is judged on the registered count, independent of tick
        assign stable[i] = (cnt == CNT_MAX);
    end

    // Only a stable level that disagrees with the current output produces an update
    assign upd      = stable & (ff1 ^ out);
    assign rise_nxt = upd & ff1;
    assign fall_nxt = upd & ~ff1;

    // Output level, edge pulses and the combined change flag all land on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= {CH{RST_VAL}};
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            out        <= (out & ~upd) | (ff1 & upd);
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_deb_multi.sv
// Bench for deb_multi (CH=4, CNT_W=3): directed stimulus pushes expected pulse events into a scoreboard.
// Latency: expected event edges are hand-computed from the drive cycle (tick=1: +10, prescaled: +29/+33).
// Backpressure: n/a; monitor samples every negedge and pops an expectation whenever a pulse appears.
module tb_deb_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick = 1'b1;
    logic [CH-1:0] in;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_change;

    int cyc        = 0;
    int n_cmp      = 0;
    int n_fail     = 0;
    int drain_seq  = 0;
    int drain_seen = 0;
    bit tick_div   = 1'b0;

    typedef struct {
        int       cyc;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } ev_t;

    ev_t        sb[$];
    ev_t        mon_e;
    logic [3:0] exp_out = 4'b0000;

    deb_multi #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .RST_VAL (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .in         (in),
        .out        (out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    // Tick seen at edge N is 1 when N%4==0 in prescale mode, else always 1
    always @(posedge clk) begin
        #1;
        tick = tick_div ? (((cyc + 1) % 4) == 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc  = at;
        e.out  = o;
        e.rise = r;
        e.fall = f;
        e.any  = |(r | f);
        sb.push_back(e);
    endtask

    // Wait (bounded) for the scoreboard to empty, then ask the monitor to verify it
    task automatic drain(input int limit);
        for (int k = 0; k < limit && sb.size() != 0; k++) step();
        drain_seq++;
    endtask

    // Monitor: reset state, pulse events against the scoreboard, level hold between events
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_out = 4'b0000;
            chk("reset_out", {28'd0, out}, 32'd0);
            chk("reset_pulse", {23'd0, any_change, fall, rise}, 32'd0);
        end else if ((rise | fall) != 4'b0000 || any_change) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {23'd0, any_change, fall, rise}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_rise", {28'd0, rise}, {28'd0, mon_e.rise});
                chk("ev_fall", {28'd0, fall}, {28'd0, mon_e.fall});
                chk("ev_any", {31'd0, any_change}, {31'd0, mon_e.any});
                chk("ev_out", {28'd0, out}, {28'd0, mon_e.out});
                exp_out = mon_e.out;
            end
        end else begin
            chk("out_hold", {28'd0, out}, {28'd0, exp_out});
        end
        if (drain_seen != drain_seq) begin
            chk("sb_drain", sb.size(), 32'd0);
            sb.delete();
            drain_seen = drain_seq;
        end
    end

    initial begin
        int d;
        // Reset with all inputs low
        rst_n = 1'b0;
        in    = 4'b0000;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (12) step();

        // Single channel rise, 9 edges after capture
        in[0] = 1'b1;
        push(cyc + 10, 4'b0001, 4'b0001, 4'b0000);
        drain(40);
        repeat (5) step();

        // Short pulse (5 clocks) and 1-clock glitch on channel 1: never reaches out
        in[1] = 1'b1;
        repeat (5) step();
        in[1] = 1'b0;
        repeat (15) step();
        in[1] = 1'b1;
        step();
        in[1] = 1'b0;
        repeat (15) step();

        // Channel 2 held past saturation, then released
        in[2] = 1'b1;
        push(cyc + 10, 4'b0101, 4'b0100, 4'b0000);
        repeat (25) step();
        in[2] = 1'b0;
        push(cyc + 10, 4'b0001, 4'b0000, 4'b0100);
        drain(40);
        repeat (5) step();

        // Prescaled counting on channel 3
        tick_div = 1'b1;
        repeat (4) step();
        while (cyc % 4 != 0) step();
        in[3] = 1'b1;
        push(cyc + 29, 4'b1001, 4'b1000, 4'b0000);
        drain(60);
        repeat (3) step();
        while (cyc % 4 != 0) step();
        d = cyc;
        in[3] = 1'b0;
        push(d + 33, 4'b0001, 4'b0000, 4'b1000);
        repeat (3) step();
        in[3] = 1'b1;          // glitch whose change edges both fall on tick=0 edges
        step();
        in[3] = 1'b0;
        drain(60);
        tick_div = 1'b0;
        repeat (5) step();

        // Clean restart, then all channels rise together
        in    = 4'b0000;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        in = 4'b1111;
        push(cyc + 10, 4'b1111, 4'b1111, 4'b0000);
        drain(40);
        repeat (3) step();

        // Reset mid-count while falling: out drops to 0, no pulse afterwards
        in = 4'b0000;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (20) step();

        // Reset mid-count while rising: a full window is needed after release
        in[0] = 1'b1;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push(cyc + 10, 4'b0001, 4'b0001, 4'b0000);
        drain(40);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
